// File: rtl/filtro_ctrl_if.sv
// ----------------------------------------------------------------------------
// filtro_ctrl_if
//   Control bundle between the biquad sequencer and its datapath.
//   The controller side (master) receives the sample strobe and drives the
//   mux selects, register enables and status flags. The datapath and strobe
//   side (slave) sees the same signals in the opposite direction.
//
//   start    sample strobe (ADC sample-ready)
//   muxS     dato1 select       : 0=fk 1=fk1 2=fk2 3=Uk
//   muxC     coefficient select : 0=-a1 1=-a2 2=b0 3=b2
//   muxZ     addend select      : 0=zero 1=Uk 2=fk 3=yk
//   en1..en4 Y(K), F(K), F(K-1), F(K-2) register loads
//   busy     sequence in progress
//   done     one-cycle pulse, Y(K) holds the new y(k)
//   overrun  sticky flag, start seen while busy (only built with FILTRO_OVERRUN_EN)
// ----------------------------------------------------------------------------
interface filtro_ctrl_if;
    logic       start;
    logic [2:0] muxS;
    logic [1:0] muxC;
    logic [1:0] muxZ;
    logic       en1;
    logic       en2;
    logic       en3;
    logic       en4;
    logic       busy;
    logic       done;
    logic       overrun;

    modport master (
        input  start,
        output muxS, muxC, muxZ, en1, en2, en3, en4, busy, done, overrun
    );

    modport slave (
        output start,
        input  muxS, muxC, muxZ, en1, en2, en3, en4, busy, done, overrun
    );
endinterface

// File: rtl/filtro_ctrl.sv
// ----------------------------------------------------------------------------
// filtro_ctrl
//   Sequencer for the band-pass biquad datapath (resul = dato1*dato2 + dato3).
//   Per sample strobe it walks SHIFT -> F1 -> F2 -> Y1 -> Y2 -> DONE:
//     SHIFT : fk2 <= fk1, fk1 <= fk
//     F1    : fk  <= u  + (-a1)*fk1
//     F2    : fk  <= fk + (-a2)*fk2
//     Y1    : yk  <= b0*fk
//     Y2    : yk  <= yk + b2*fk2
//   Each compute step holds its mux codes for STEP_WAIT+1 cycles; its enable
//   is high only in the last of those cycles.
//
//   Parameters : STEP_WAIT (0..15) extra settle cycles per compute step.
//   Ports      : clk    rising-edge clock
//                reset  asynchronous, active-low
//                bus    filtro_ctrl_if.master (start in, controls/status out)
//   Option     : `define FILTRO_OVERRUN_EN builds the sticky overrun flag;
//                without it overrun is tied low.
// ----------------------------------------------------------------------------
module filtro_ctrl #(
    parameter int unsigned STEP_WAIT = 0
) (
    input  logic          clk,
    input  logic          reset,
    filtro_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_F1,
        ST_F2,
        ST_Y1,
        ST_Y2,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [2:0] muxS;
        logic [1:0] muxC;
        logic [1:0] muxZ;
        logic       en1;
        logic       en2;
        logic       en3;
        logic       en4;
        logic       busy;
        logic       done;
    } ctrl_t;

    localparam logic [3:0] WAIT_LOAD = 4'(STEP_WAIT);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    ctrl_t      ctrl_q;

    // Moore decode of a state; 'last' marks the final cycle of a compute step.
    function automatic ctrl_t decode(input state_t s, input logic last);
        ctrl_t c;
        c = '0;
        c.busy = (s != ST_IDLE);
        case (s)
            ST_SHIFT: begin
                c.en3 = 1'b1;
                c.en4 = 1'b1;
            end
            ST_F1: begin
                c.muxS = 3'd1; c.muxC = 2'd0; c.muxZ = 2'd1;
                c.en2  = last;
            end
            ST_F2: begin
                c.muxS = 3'd2; c.muxC = 2'd1; c.muxZ = 2'd2;
                c.en2  = last;
            end
            ST_Y1: begin
                c.muxS = 3'd0; c.muxC = 2'd2; c.muxZ = 2'd0;
                c.en1  = last;
            end
            ST_Y2: begin
                c.muxS = 3'd2; c.muxC = 2'd3; c.muxZ = 2'd3;
                c.en1  = last;
            end
            ST_DONE: c.done = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE:  if (bus.start) state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                state_nxt = ST_F1;
                cnt_nxt   = WAIT_LOAD;
            end
            ST_F1, ST_F2, ST_Y1, ST_Y2: begin
                if (cnt == 4'd0) begin
                    cnt_nxt = WAIT_LOAD;
                    case (state)
                        ST_F1:   state_nxt = ST_F2;
                        ST_F2:   state_nxt = ST_Y1;
                        ST_Y1:   state_nxt = ST_Y2;
                        default: state_nxt = ST_DONE;
                    endcase
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they equal
    // the Moore decode of the state register while coming straight off flops.
    // NOTE: sequential state uses non-blocking assignments so all flops update
    // together on the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= 4'd0;
            ctrl_q <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            ctrl_q <= decode(state_nxt, cnt_nxt == 4'd0);
        end
    end

    assign bus.muxS = ctrl_q.muxS;
    assign bus.muxC = ctrl_q.muxC;
    assign bus.muxZ = ctrl_q.muxZ;
    assign bus.en1  = ctrl_q.en1;
    assign bus.en2  = ctrl_q.en2;
    assign bus.en3  = ctrl_q.en3;
    assign bus.en4  = ctrl_q.en4;
    assign bus.busy = ctrl_q.busy;
    assign bus.done = ctrl_q.done;

`ifdef FILTRO_OVERRUN_EN
    // Sticky: a strobe arriving while busy is dropped but remembered here.
    logic overrun_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_q <= 1'b0;
        end else if (bus.start && ctrl_q.busy) begin
            overrun_q <= 1'b1;
        end
    end

    assign bus.overrun = overrun_q;
`else
    assign bus.overrun = 1'b0;
`endif

endmodule

// File: tb/tb_filtro_ctrl.sv
// ----------------------------------------------------------------------------
// tb_filtro_ctrl
//   Directed bench for filtro_ctrl. Two instances: STEP_WAIT=0 (with a small
//   Q1.14 biquad datapath model attached) and STEP_WAIT=3.
// ----------------------------------------------------------------------------
module tb_filtro_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    filtro_ctrl_if if0 ();
    filtro_ctrl_if if3 ();

    filtro_ctrl #(.STEP_WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(if0.master));
    filtro_ctrl #(.STEP_WAIT(3)) dut3 (.clk(clk), .reset(reset), .bus(if3.master));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {muxS, muxC, muxZ, en1, en2, en3, en4, busy, done}
    function automatic logic [12:0] pk(input logic [2:0] s, input logic [1:0] c,
                                       input logic [1:0] z, input logic e1, input logic e2,
                                       input logic e3, input logic e4, input logic b,
                                       input logic d);
        return {s, c, z, e1, e2, e3, e4, b, d};
    endfunction

    // Compute-step vectors: st 0=F1 1=F2 2=Y1 3=Y2, en = last cycle of step.
    function automatic logic [12:0] step_vec(input int st, input logic en);
        case (st)
            0:       return pk(3'd1, 2'd1 - 2'd1, 2'd1, 1'b0, en, 1'b0, 1'b0, 1'b1, 1'b0);
            1:       return pk(3'd2, 2'd1, 2'd2, 1'b0, en, 1'b0, 1'b0, 1'b1, 1'b0);
            2:       return pk(3'd0, 2'd2, 2'd0, en, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            default: return pk(3'd2, 2'd3, 2'd3, en, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        endcase
    endfunction

    logic [12:0] obs0, obs3;
    assign obs0 = {if0.muxS, if0.muxC, if0.muxZ, if0.en1, if0.en2, if0.en3, if0.en4, if0.busy, if0.done};
    assign obs3 = {if3.muxS, if3.muxC, if3.muxZ, if3.en1, if3.en2, if3.en3, if3.en4, if3.busy, if3.done};

    logic [12:0] v_shift, v_done;
    assign v_shift = pk(3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    assign v_done  = pk(3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

`ifdef FILTRO_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    // ---------------- Q1.14 datapath model on instance 0 -------------------
    logic signed [15:0] u, fk, fk1, fk2, yk;
    logic signed [15:0] dato1, dato2, dato3, resul;
    logic signed [31:0] prod;

    localparam logic signed [15:0] C_NA1 = 16'sd8192;   //  0.5
    localparam logic signed [15:0] C_NA2 = -16'sd4096;  // -0.25
    localparam logic signed [15:0] C_B0  = 16'sd3277;   //  0.2
    localparam logic signed [15:0] C_B2  = -16'sd3277;  // -0.2

    always_comb begin
        dato1 = fk;
        case (if0.muxS)
            3'd1:    dato1 = fk1;
            3'd2:    dato1 = fk2;
            3'd3:    dato1 = u;
            default: dato1 = fk;
        endcase
        case (if0.muxC)
            2'd0:    dato2 = C_NA1;
            2'd1:    dato2 = C_NA2;
            2'd2:    dato2 = C_B0;
            default: dato2 = C_B2;
        endcase
        case (if0.muxZ)
            2'd1:    dato3 = u;
            2'd2:    dato3 = fk;
            2'd3:    dato3 = yk;
            default: dato3 = 16'sd0;
        endcase
        prod  = dato1 * dato2;
        resul = 16'(prod >>> 14) + dato3;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fk <= '0; fk1 <= '0; fk2 <= '0; yk <= '0;
        end else begin
            if (if0.en2) fk  <= resul;
            if (if0.en3) fk1 <= fk;
            if (if0.en4) fk2 <= fk1;
            if (if0.en1) yk  <= resul;
        end
    end

    int done_cnt0 = 0;
    always @(posedge clk) if (if0.done) done_cnt0 <= done_cnt0 + 1;

    // --------------------------- stimulus helpers ---------------------------
    // Returns at the falling edge inside the SHIFT cycle.
    task automatic pulse_start0();
        @(negedge clk) if0.start = 1'b1;
        @(negedge clk) if0.start = 1'b0;
    endtask

    // Runs one sample on instance 0; n counts cycles after the start edge.
    task automatic run_sample(input logic signed [15:0] uval, input string tag,
                              input logic signed [15:0] yexp);
        int n;
        u = uval;
        pulse_start0();
        check({tag, "_busy"}, 32'(if0.busy), 32'd1);
        n = 1;
        while (!if0.done && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd6);
        check({tag, "_y"}, 32'(yk), 32'(yexp));
    endtask

    // ------------------------------- main -----------------------------------
    initial begin
        int dc;
        if0.start = 1'b1;
        if3.start = 1'b1;
        u = '0;

        // Reset held with start high: everything at reset values.
        repeat (3) @(negedge clk);
        check("rst_out0", 32'(obs0), 32'd0);
        check("rst_out3", 32'(obs3), 32'd0);
        check("rst_ovr",  32'(if0.overrun), 32'd0);
        if0.start = 1'b0;
        if3.start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("idle_out0", 32'(obs0), 32'd0);

        // Impulse 1.0 then zeros: y = 0.2, 0.1, -0.2 in Q1.14 (truncating).
        run_sample(16'sd16384, "s0", 16'sd3277);
        run_sample(16'sd0,     "s1", 16'sd1638);
        run_sample(16'sd0,     "s2", -16'sd3277);
        check("ovr_clean", 32'(if0.overrun), 32'd0);

        // Exact per-state sequence, STEP_WAIT=0.
        @(negedge clk);
        pulse_start0();
        check("seq_shift", 32'(obs0), 32'(v_shift));
        for (int st = 0; st < 4; st++) begin
            @(negedge clk);
            check($sformatf("seq_step%0d", st), 32'(obs0), 32'(step_vec(st, 1'b1)));
        end
        @(negedge clk);
        check("seq_done", 32'(obs0), 32'(v_done));
        @(negedge clk);
        check("seq_idle", 32'(obs0), 32'd0);

        // STEP_WAIT=3: 4 cycles per step, enable only in the 4th, done at cycle 18.
        @(negedge clk) if3.start = 1'b1;
        @(negedge clk) if3.start = 1'b0;
        check("w3_shift", 32'(obs3), 32'(v_shift));
        for (int st = 0; st < 4; st++) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check($sformatf("w3_s%0d_c%0d", st, k), 32'(obs3), 32'(step_vec(st, k == 3)));
            end
        end
        @(negedge clk);
        check("w3_done18", 32'(obs3), 32'(v_done));
        @(negedge clk);
        check("w3_idle", 32'(obs3), 32'd0);

        // start during F2 and during DONE: ignored, no restart.
        pulse_start0();
        @(negedge clk);                 // F1
        @(negedge clk) if0.start = 1'b1; // F2
        @(negedge clk) if0.start = 1'b0; // Y1
        check("busy_y1", 32'(obs0), 32'(step_vec(2, 1'b1)));
        @(negedge clk);                 // Y2
        @(negedge clk);                 // DONE
        check("busy_done", 32'(obs0), 32'(v_done));
        if0.start = 1'b1;
        @(negedge clk) if0.start = 1'b0;
        check("no_restart", 32'(obs0), 32'd0);
        dc = done_cnt0;
        repeat (8) @(negedge clk);
        check("done_cnt", 32'(done_cnt0), 32'(dc));
        check("overrun", 32'(if0.overrun), 32'(OVR_EXP));

        // Asynchronous reset during Y1.
        pulse_start0();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_y1", 32'(obs0), 32'(step_vec(2, 1'b1)));
        #2 reset = 1'b0;
        #1;
        check("async_rst", 32'(obs0), 32'd0);
        check("async_ovr", 32'(if0.overrun), 32'd0);
        @(negedge clk) reset = 1'b1;
        check("post_rst", 32'(obs0), 32'd0);
        run_sample(16'sd0, "rec", 16'sd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
